// File: rtl/vga_rect_filler.sv
`default_nettype none
// ============================================================================
// Module  : vga_rect_filler
// Brief   : Fills a clipped screen rectangle with one colour, one pixel per
//           accepted video-memory write, in raster order.
// Revision: 1.0
// ============================================================================
module vga_rect_filler #(
    parameter string RESOLUTION              = "320x240",
    parameter int    BITS_PER_COLOUR_CHANNEL = 1,
    parameter string MONOCHROME              = "FALSE",
    localparam int   XW   = (RESOLUTION == "640x480") ? 10 : 9,
    localparam int   YW   = (RESOLUTION == "640x480") ? 9 : 8,
    localparam int   CW   = (MONOCHROME == "TRUE") ? 1 : 3 * BITS_PER_COLOUR_CHANNEL
) (
    input  logic          vga_clock,
    input  logic          resetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [XW-1:0] cmd_x,
    input  logic [YW-1:0] cmd_y,
    input  logic [XW-1:0] cmd_w,
    input  logic [YW-1:0] cmd_h,
    input  logic [CW-1:0] cmd_colour,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          plot,
    input  logic          wr_ready,
    output logic          busy,
    output logic          done
);

    localparam int XMAX = (RESOLUTION == "640x480") ? 640 : 320;
    localparam int YMAX = (RESOLUTION == "640x480") ? 480 : 240;

    localparam logic [XW:0] X_LIM = (XW+1)'(XMAX - 1);
    localparam logic [YW:0] Y_LIM = (YW+1)'(YMAX - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;

    logic [XW-1:0] x_first, x_first_nxt;
    logic [XW-1:0] x_last,  x_last_nxt;
    logic [YW-1:0] y_last,  y_last_nxt;
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_nxt;
    logic [CW-1:0] colour_nxt;
    logic          plot_nxt;
    logic          cmd_ready_nxt;
    logic          busy_nxt;
    logic          done_nxt;

    // One extra bit so the far edge cannot wrap before it is clipped.
    logic [XW:0]   x_end_raw;
    logic [YW:0]   y_end_raw;
    logic [XW-1:0] x_end_clip;
    logic [YW-1:0] y_end_clip;
    logic          cmd_empty;
    logic          accept;
    logic          advance;

    always_comb begin
        x_end_raw  = {1'b0, cmd_x} + {1'b0, cmd_w} - (XW+1)'(1);
        y_end_raw  = {1'b0, cmd_y} + {1'b0, cmd_h} - (YW+1)'(1);
        x_end_clip = (x_end_raw > X_LIM) ? X_LIM[XW-1:0] : x_end_raw[XW-1:0];
        y_end_clip = (y_end_raw > Y_LIM) ? Y_LIM[YW-1:0] : y_end_raw[YW-1:0];
        cmd_empty  = (cmd_w == '0) || (cmd_h == '0) ||
                     ({1'b0, cmd_x} > X_LIM) || ({1'b0, cmd_y} > Y_LIM);
        accept     = cmd_valid && cmd_ready;
        advance    = plot && wr_ready;
    end

    always_comb begin
        state_nxt   = state;
        x_first_nxt = x_first;
        x_last_nxt  = x_last;
        y_last_nxt  = y_last;
        x_nxt       = x;
        y_nxt       = y;
        colour_nxt  = colour;
        plot_nxt    = plot;

        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    x_first_nxt = cmd_x;
                    x_last_nxt  = x_end_clip;
                    y_last_nxt  = y_end_clip;
                    colour_nxt  = cmd_colour;
                    if (cmd_empty) begin
                        state_nxt = S_DONE;
                        plot_nxt  = 1'b0;
                    end else begin
                        state_nxt = S_FILL;
                        x_nxt     = cmd_x;
                        y_nxt     = cmd_y;
                        plot_nxt  = 1'b1;
                    end
                end
            end
            S_FILL: begin
                if (advance) begin
                    if (x == x_last) begin
                        if (y == y_last) begin
                            state_nxt = S_DONE;
                            plot_nxt  = 1'b0;
                        end else begin
                            x_nxt = x_first;
                            y_nxt = y + YW'(1);
                        end
                    end else begin
                        x_nxt = x + XW'(1);
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                plot_nxt  = 1'b0;
            end
            default: begin
                state_nxt = S_IDLE;
                plot_nxt  = 1'b0;
            end
        endcase

        // Handshake flags follow the state being entered so they stay registered.
        cmd_ready_nxt = (state_nxt == S_IDLE);
        busy_nxt      = (state_nxt != S_IDLE);
        done_nxt      = (state_nxt == S_DONE);
    end

    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            x_first   <= '0;
            x_last    <= '0;
            y_last    <= '0;
            x         <= '0;
            y         <= '0;
            colour    <= '0;
            plot      <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            x_first   <= x_first_nxt;
            x_last    <= x_last_nxt;
            y_last    <= y_last_nxt;
            x         <= x_nxt;
            y         <= y_nxt;
            colour    <= colour_nxt;
            plot      <= plot_nxt;
            cmd_ready <= cmd_ready_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

endmodule
`default_nettype wire
